// File: rtl/net_frame_fifo_if.sv
// Handshake bundle for the frame-aware FIFO: write-side and read-side
// controls plus status. master = user of the FIFO, slave = the FIFO itself.
interface net_frame_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wr_last;
    logic                  wr_drop;
    logic                  full;
    logic                  afull;
    logic [ADDR_WIDTH:0]   used_cnt;
    logic                  wr_ovf;
    logic                  rd_en;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rd_last;
    logic [ADDR_WIDTH:0]   rd_cnt;
    logic                  aempty;
    logic [ADDR_WIDTH:0]   frame_cnt;

    modport master (
        output flush, wr_en, wdata, wr_last, wr_drop, rd_en,
        input  full, afull, used_cnt, wr_ovf,
        input  rd_valid, rdata, rd_last, rd_cnt, aempty, frame_cnt
    );

    modport slave (
        input  flush, wr_en, wdata, wr_last, wr_drop, rd_en,
        output full, afull, used_cnt, wr_ovf,
        output rd_valid, rdata, rd_last, rd_cnt, aempty, frame_cnt
    );
endinterface

// File: rtl/net_frame_fifo.sv
// Frame-aware FIFO: words become visible only once their frame's last word
// is written; dropped or overflowed frames are rolled back as a whole.
module net_frame_fifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 6,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input logic            clk,
    input logic            rst,
    net_frame_fifo_if.slave bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t DEPTH_P  = ptr_t'(DEPTH);
    localparam ptr_t AFULL_P  = ptr_t'(AFULL_THRESH);
    localparam ptr_t AEMPTY_P = ptr_t'(AEMPTY_THRESH);
    localparam ptr_t ONE      = ptr_t'(1);

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        BAD
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH:0] mem [DEPTH];

    ptr_t wptr, cptr, rptr, frame_cnt;
    logic wr_ovf_q;

    ptr_t                used_cnt_w, rd_cnt_w;
    logic                full_w, rd_valid_w, pop;
    logic                wr_accept, do_commit, do_rollback, ovf_set;
    logic [DATA_WIDTH:0] head;

    assign used_cnt_w = wptr - rptr;
    assign rd_cnt_w   = cptr - rptr;
    assign full_w     = (used_cnt_w == DEPTH_P);
    assign rd_valid_w = (rd_cnt_w != '0);
    assign pop        = bus.rd_en & rd_valid_w;
    assign head       = mem[rptr[ADDR_WIDTH-1:0]];

    assign bus.full      = full_w;
    assign bus.afull     = (used_cnt_w >= AFULL_P);
    assign bus.used_cnt  = used_cnt_w;
    assign bus.wr_ovf    = wr_ovf_q;
    assign bus.rd_valid  = rd_valid_w;
    assign bus.rdata     = head[DATA_WIDTH-1:0];
    assign bus.rd_last   = head[DATA_WIDTH];
    assign bus.rd_cnt    = rd_cnt_w;
    assign bus.aempty    = (rd_cnt_w <= AEMPTY_P);
    assign bus.frame_cnt = frame_cnt;

    // Frame state register; flush forces IDLE ahead of any transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (bus.flush) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next frame state from the write-side request and the registered full flag.
    always_comb begin
        state_nxt = state;
        if (bus.wr_drop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wr_en) begin
                        if (!full_w) begin
                            state_nxt = bus.wr_last ? IDLE : OPEN;
                        end else if (!bus.wr_last) begin
                            state_nxt = BAD;
                        end
                    end
                end
                OPEN: begin
                    if (bus.wr_en) begin
                        if (full_w) begin
                            state_nxt = BAD;
                        end else if (bus.wr_last) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                BAD: begin
                    if (bus.wr_en && bus.wr_last) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Per-cycle write-side actions decoded from the current frame state.
    always_comb begin
        wr_accept   = bus.wr_en & ~full_w & ~bus.wr_drop & (state != BAD);
        do_commit   = wr_accept & bus.wr_last;
        do_rollback = ~bus.wr_drop & bus.wr_en & bus.wr_last & (state == BAD);
        ovf_set     = ~bus.wr_drop & bus.wr_en & bus.wr_last &
                      ((state == BAD) | ((state == IDLE) & full_w));
    end

    // Pointer, frame counter and overflow pulse update; flush outranks everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            cptr      <= '0;
            rptr      <= '0;
            frame_cnt <= '0;
            wr_ovf_q  <= 1'b0;
        end else if (bus.flush) begin
            wptr      <= rptr;
            cptr      <= rptr;
            frame_cnt <= '0;
            wr_ovf_q  <= 1'b0;
        end else begin
            wr_ovf_q <= ovf_set;
            if (bus.wr_drop || do_rollback) begin
                wptr <= cptr;
            end else if (wr_accept) begin
                wptr <= wptr + ONE;
            end
            if (do_commit) begin
                cptr <= wptr + ONE;
            end
            if (pop) begin
                rptr <= rptr + ONE;
            end
            // A commit and an end-of-frame pop in the same cycle cancel out.
            if (do_commit && !(pop && head[DATA_WIDTH])) begin
                frame_cnt <= frame_cnt + ONE;
            end else if (!do_commit && pop && head[DATA_WIDTH]) begin
                frame_cnt <= frame_cnt - ONE;
            end
        end
    end

    // Storage write of {wr_last, wdata}; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_accept && !bus.flush) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= {bus.wr_last, bus.wdata};
        end
    end
endmodule

// File: tb/tb_net_frame_fifo.sv
// Bench for net_frame_fifo: queue-based frame model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_net_frame_fifo;
    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_on = 1'b0;

    int total = 0;
    int bad   = 0;

    net_frame_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    net_frame_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AFULL_THRESH(60),
        .AEMPTY_THRESH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: committed words, words of the open frame, and whether the
    // open frame has overflowed and is being thrown away.
    logic [DW:0] cq[$];
    logic [DW:0] uq[$];
    bit          m_discard;
    bit          m_ovf;

    // Model update on each rising edge from the inputs presented to the DUT.
    always @(posedge clk or posedge rst) begin : model
        bit was_full;
        bit can_pop;
        if (rst || bus.flush) begin
            cq.delete();
            uq.delete();
            m_discard = 1'b0;
            m_ovf     = 1'b0;
        end else begin
            was_full = (cq.size() + uq.size()) == DEPTH;
            can_pop  = bus.rd_en && (cq.size() > 0);
            m_ovf    = 1'b0;
            if (can_pop) void'(cq.pop_front());
            if (bus.wr_drop) begin
                uq.delete();
                m_discard = 1'b0;
            end else if (m_discard) begin
                if (bus.wr_en && bus.wr_last) begin
                    uq.delete();
                    m_discard = 1'b0;
                    m_ovf     = 1'b1;
                end
            end else if (bus.wr_en) begin
                if (!was_full) begin
                    uq.push_back({bus.wr_last, bus.wdata});
                    if (bus.wr_last) begin
                        foreach (uq[i]) cq.push_back(uq[i]);
                        uq.delete();
                    end
                end else if (bus.wr_last && uq.size() == 0) begin
                    m_ovf = 1'b1;
                end else begin
                    m_discard = 1'b1;
                end
            end
        end
    end

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        if (!rst && chk_on) begin : cmp
            int u, r, f;
            u = cq.size() + uq.size();
            r = cq.size();
            f = 0;
            foreach (cq[i]) if (cq[i][DW]) f++;
            check("used_cnt", int'(bus.used_cnt), u);
            check("rd_cnt", int'(bus.rd_cnt), r);
            check("frame_cnt", int'(bus.frame_cnt), f);
            check("full", int'(bus.full), int'(u == DEPTH));
            check("afull", int'(bus.afull), int'(u >= 60));
            check("aempty", int'(bus.aempty), int'(r <= 4));
            check("rd_valid", int'(bus.rd_valid), int'(r != 0));
            check("wr_ovf", int'(bus.wr_ovf), int'(m_ovf));
            if (r != 0) begin
                check("rdata", int'(bus.rdata), int'(cq[0][DW-1:0]));
                check("rd_last", int'(bus.rd_last), int'(cq[0][DW]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] d, input logic l);
        bus.wr_en   = 1'b1;
        bus.wdata   = d;
        bus.wr_last = l;
        tick();
        bus.wr_en   = 1'b0;
        bus.wr_last = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [DW-1:0] d, input logic l);
        check({name, "_data"}, int'(bus.rdata), int'(d));
        check({name, "_last"}, int'(bus.rd_last), int'(l));
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ovf_seen;
        bus.flush   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wdata   = '0;
        bus.wr_last = 1'b0;
        bus.wr_drop = 1'b0;
        bus.rd_en   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_on = 1'b1;

        // Reset state
        check("rst_full", int'(bus.full), 0);
        check("rst_afull", int'(bus.afull), 0);
        check("rst_used", int'(bus.used_cnt), 0);
        check("rst_rd_cnt", int'(bus.rd_cnt), 0);
        check("rst_aempty", int'(bus.aempty), 1);
        check("rst_rd_valid", int'(bus.rd_valid), 0);
        check("rst_frame_cnt", int'(bus.frame_cnt), 0);
        check("rst_wr_ovf", int'(bus.wr_ovf), 0);

        // 1: three-word frame becomes visible only after its last word
        wr(32'hA1, 1'b0);
        check("t1_valid_a1", int'(bus.rd_valid), 0);
        wr(32'hA2, 1'b0);
        check("t1_valid_a2", int'(bus.rd_valid), 0);
        check("t1_used_a2", int'(bus.used_cnt), 2);
        wr(32'hA3, 1'b1);
        check("t1_rd_cnt", int'(bus.rd_cnt), 3);
        check("t1_frame_cnt", int'(bus.frame_cnt), 1);
        pop_expect("t1_p1", 32'hA1, 1'b0);
        pop_expect("t1_p2", 32'hA2, 1'b0);
        pop_expect("t1_p3", 32'hA3, 1'b1);
        check("t1_frame_cnt_end", int'(bus.frame_cnt), 0);
        check("t1_valid_end", int'(bus.rd_valid), 0);

        // 2: exactly DEPTH words fit; a further write is refused
        for (int i = 1; i <= 64; i++) wr(32'h200 + i, i == 64);
        check("t2_full", int'(bus.full), 1);
        check("t2_used", int'(bus.used_cnt), 64);
        check("t2_rd_cnt", int'(bus.rd_cnt), 64);
        check("t2_afull", int'(bus.afull), 1);
        wr(32'hDEAD, 1'b0);
        check("t2_used_after_refuse", int'(bus.used_cnt), 64);
        bus.wr_drop = 1'b1;
        tick();
        bus.wr_drop = 1'b0;
        check("t2_head", int'(bus.rdata), 32'h201);
        bus.rd_en = 1'b1;
        repeat (64) tick();
        bus.rd_en = 1'b0;
        check("t2_drained_valid", int'(bus.rd_valid), 0);
        check("t2_drained_used", int'(bus.used_cnt), 0);

        // 3: overflowing an open frame discards it at wr_last with one pulse
        ovf_seen = 0;
        for (int i = 0; i < 70; i++) begin
            wr(32'h300 + i, 1'b0);
            if (bus.wr_ovf) ovf_seen++;
        end
        wr(32'h3FF, 1'b1);
        if (bus.wr_ovf) ovf_seen++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.wr_ovf) ovf_seen++;
        end
        check("t3_ovf_pulses", ovf_seen, 1);
        check("t3_used", int'(bus.used_cnt), 0);
        check("t3_rd_cnt", int'(bus.rd_cnt), 0);
        check("t3_frame_cnt", int'(bus.frame_cnt), 0);

        // 4: drop of an open frame leaves the committed one intact
        wr(32'hF101, 1'b0);
        wr(32'hF102, 1'b1);
        for (int i = 0; i < 5; i++) wr(32'hF200 + i, 1'b0);
        check("t4_used_open", int'(bus.used_cnt), 7);
        bus.wr_drop = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wdata   = 32'hBAD;
        tick();
        bus.wr_drop = 1'b0;
        bus.wr_en   = 1'b0;
        check("t4_used_drop", int'(bus.used_cnt), 2);
        check("t4_frame_cnt", int'(bus.frame_cnt), 1);
        pop_expect("t4_p1", 32'hF101, 1'b0);
        pop_expect("t4_p2", 32'hF102, 1'b1);
        check("t4_valid_end", int'(bus.rd_valid), 0);

        // 5: one-word frames streamed with continuous reads across pointer wrap
        bus.rd_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            wr(32'h5000 + i, 1'b1);
            check("t5_frame_cnt", int'(bus.frame_cnt), 1);
        end
        check("t5_last_head", int'(bus.rdata), 32'h5000 + 199);
        tick();
        bus.rd_en = 1'b0;
        check("t5_valid_end", int'(bus.rd_valid), 0);
        check("t5_frame_cnt_end", int'(bus.frame_cnt), 0);

        // 6: flush with committed data and an open frame, overriding other requests
        for (int i = 0; i < 10; i++) wr(32'h600 + i, (i % 5) == 4);
        wr(32'h6A0, 1'b0);
        wr(32'h6A1, 1'b0);
        wr(32'h6A2, 1'b0);
        check("t6_used_pre", int'(bus.used_cnt), 13);
        check("t6_frames_pre", int'(bus.frame_cnt), 2);
        bus.flush   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_last = 1'b1;
        bus.wdata   = 32'hBEEF;
        bus.rd_en   = 1'b1;
        tick();
        bus.flush   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_last = 1'b0;
        bus.rd_en   = 1'b0;
        check("t6_used", int'(bus.used_cnt), 0);
        check("t6_valid", int'(bus.rd_valid), 0);
        check("t6_aempty", int'(bus.aempty), 1);
        check("t6_frame_cnt", int'(bus.frame_cnt), 0);
        wr(32'h700, 1'b0);
        wr(32'h701, 1'b1);
        check("t6_rd_cnt_new", int'(bus.rd_cnt), 2);
        pop_expect("t6_p1", 32'h700, 1'b0);
        pop_expect("t6_p2", 32'h701, 1'b1);
        check("t6_valid_end", int'(bus.rd_valid), 0);

        tick();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/net_frame_fifo.md
Name: net_frame_fifo

Overview:
- Parametrised frame-aware FIFO for the ENET datapath. Sits between the MAC receive or transmit logic and the DMA.
- The write side streams words tagged with end-of-frame. A frame is visible to the reader only after its last word is accepted.
- Bad or overflowed frames are rolled back atomically, so the reader never sees partial frames.
- Adds over the plain FIFO: full/almost flags, a correct DEPTH-capable count, frame counting, drop and overflow handling.

Parameters:
DATA_WIDTH, 32, data word width
ADDR_WIDTH, 6, log2 of depth; DEPTH = 2**ADDR_WIDTH
AFULL_THRESH, 2**ADDR_WIDTH-4, afull asserted when used_cnt >= this value
AEMPTY_THRESH, 4, aempty asserted when rd_cnt <= this value

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of all contents and frame state; highest priority
wr_en  in  1  write request for wdata/wr_last
wdata  in  DATA_WIDTH  write data
wr_last  in  1  marks the final word of a frame
wr_drop  in  1  discard the currently open, uncommitted frame
full  out  1  used_cnt == DEPTH
afull  out  1  used_cnt >= AFULL_THRESH
used_cnt  out  ADDR_WIDTH+1  words held, committed plus uncommitted
wr_ovf  out  1  one-cycle pulse: an overflowed frame was discarded at its wr_last
rd_en  in  1  pop the head word
rd_valid  out  1  rd_cnt != 0
rdata  out  DATA_WIDTH  head word, combinational from memory (show-ahead)
rd_last  out  1  end-of-frame tag of the head word
rd_cnt  out  ADDR_WIDTH+1  committed words available to read
aempty  out  1  rd_cnt <= AEMPTY_THRESH
frame_cnt  out  ADDR_WIDTH+1  complete frames available to read

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+1) array holding {wr_last, wdata}. Memory is not reset.
- Pointers: wptr (speculative), cptr (commit) and rptr, each ADDR_WIDTH+1 bits. The MSB is the wrap bit; the low bits index memory.
- Counts: used_cnt = wptr - rptr; rd_cnt = cptr - rptr; both modulo 2**(ADDR_WIDTH+1).
- Status outputs are derived combinationally from registered state only.
- Reset values: all pointers 0, frame_cnt 0, frame state IDLE, wr_ovf 0. Consequently full=0, afull=0, rd_valid=0, rd_cnt=0, used_cnt=0, aempty=1.
- Write is accepted when wr_en & !full & !wr_drop & state != BAD. An accepted write stores the word at wptr[ADDR_WIDTH-1:0] and increments wptr.
- full is evaluated on the registered count. A write while full is refused even if rd_en is asserted in the same cycle.
- Frame state machine:
  - IDLE: an accepted write without wr_last goes to OPEN. An accepted write with wr_last commits a one-word frame and stays in IDLE.
  - OPEN: an accepted write with wr_last commits (cptr <= wptr+1, frame_cnt +1) and goes to IDLE. wr_en while full goes to BAD.
  - BAD: all writes are ignored. wr_en & wr_last rolls back (wptr <= cptr), pulses wr_ovf for one cycle and goes to IDLE.
  - From IDLE, wr_en while full without wr_last enters BAD. With wr_last it only pulses wr_ovf; nothing is stored.
- wr_drop in any state: wptr <= cptr, state goes to IDLE, and any wr_en in the same cycle is discarded. There is no wr_ovf pulse.
- Read: a pop occurs when rd_en & rd_valid; it increments rptr. rd_en while !rd_valid is ignored. Popping a word with rd_last=1 decrements frame_cnt.
- Latency: a committed frame is visible the cycle after its wr_last write (rd_valid, rd_cnt, frame_cnt all update). A pop updates the head on the next cycle.
- Simultaneous events:
  - A commit and a pop of an end-of-frame word in the same cycle leave frame_cnt unchanged.
  - A write and a pop in the same cycle leave used_cnt unchanged.
  - A rollback concurrent with a pop applies both: wptr <= cptr, rptr+1.
- flush: rptr keeps its value; wptr <= rptr; cptr <= rptr; frame_cnt <= 0; state IDLE; wr_ovf 0. Flush overrides every concurrent wr_en, rd_en and wr_drop.
- Wrap-around is carried by the MSB bits, so full at DEPTH words is distinguished from empty. Exactly DEPTH words are storable.
- Reset mid-frame discards all contents, with no wr_ovf.

Test Plan:
1. Reset, then write a 3-word frame A1..A3 with wr_last on A3. rd_valid is 0 until the cycle after A3, then rd_cnt=3, frame_cnt=1. Popping yields A1, A2, A3 with rd_last=0,0,1, after which frame_cnt=0.
2. DEPTH=64: write 64 words with wr_last on word 64. full=1, used_cnt=64, rd_cnt=64. A 65th wr_en is refused and used_cnt stays 64.
3. Open a frame, write 70 words without reading, then wr_last. Exactly one wr_ovf pulse; afterwards used_cnt=0, rd_cnt=0 and frame_cnt unchanged.
4. Commit frame F1 (2 words), write 5 words of F2, then assert wr_drop. used_cnt returns to 2. The reader sees only F1, then rd_valid=0.
5. Run 200 one-word frames with continuous rd_en. Data order is preserved across pointer wrap and frame_cnt never exceeds 1. With commit and end-of-frame pop in the same cycle, frame_cnt holds steady.
6. With 10 committed words and an open frame, assert flush for one cycle. Next cycle used_cnt=0, rd_valid=0, aempty=1; new frames write and read correctly.
